// File: rtl/uplink_rx_fifo.sv
// uplink_rx_fifo: ground-uplink serial receiver with a show-ahead word FIFO.
//   Samples LANES data bits plus a check bit on each rpulse strobe, assembles
//   WORD_W-bit frames after a sync symbol, pushes good frames into a
//   FIFO_DEPTH-entry FIFO and tracks overflow / check-bit errors.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rpulse, rd, rcheck async strobe, data lanes (rd[LANES-1] = MSB), check bit
//   rd_echo           assembly-register MSBs shifted out on each data strobe
//   pop, clr_err      CPU FIFO pop strobe, sticky-error clear
//   irq_en, irq       interrupt enable, interrupt (combinational from flags)
//   rd_data           FIFO head, 0 when empty
//   fifo_empty/full/count, overflow, parity_err, err_count, frame_busy  status
module uplink_rx_fifo #(
    parameter int unsigned WORD_W     = 16,
    parameter int unsigned LANES      = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ERR_W      = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  rpulse,
    input  logic [LANES-1:0]                      rd,
    input  logic                                  rcheck,
    output logic [LANES-1:0]                      rd_echo,
    input  logic                                  pop,
    input  logic                                  clr_err,
    input  logic                                  irq_en,
    output logic [WORD_W-1:0]                     rd_data,
    output logic                                  fifo_empty,
    output logic                                  fifo_full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_count,
    output logic                                  overflow,
    output logic                                  parity_err,
    output logic [ERR_W-1:0]                      err_count,
    output logic                                  frame_busy,
    output logic                                  irq
);

    localparam int unsigned BEATS  = WORD_W / LANES;
    localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {IDLE, RECV} state_t;

    state_t state, state_nxt;

    // Two-flop synchronisers plus a delayed copy of rpulse for edge detection
    logic [1:0]       pulse_sync;
    logic             pulse_d;
    logic [LANES-1:0] rd_s1, rd_s2;
    logic             check_s1, check_s2;

    logic [WORD_W-1:0] asm_word;
    logic [CNT_W-1:0]  beat_cnt;
    logic              frame_valid;

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_ptr_nxt;
    logic [FCNT_W-1:0] count_nxt;
    logic [WORD_W-1:0] head_nxt;
    logic [ERR_W-1:0]  err_base, err_nxt;

    logic              strobe, sync_sym, shift, done;
    logic              frame_ok, do_pop, push_ok, do_push, drop, bad;
    logic [WORD_W-1:0] word_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_sync <= '0;
            pulse_d    <= 1'b0;
            rd_s1      <= '0;
            rd_s2      <= '0;
            check_s1   <= 1'b0;
            check_s2   <= 1'b0;
        end else begin
            pulse_sync <= {pulse_sync[0], rpulse};
            pulse_d    <= pulse_sync[1];
            rd_s1      <= rd;
            rd_s2      <= rd_s1;
            check_s1   <= rcheck;
            check_s2   <= check_s1;
        end
    end

    assign strobe   = pulse_sync[1] & ~pulse_d;
    // Valid data beats with all-ones lanes carry check 0 (LANES even), so they never alias sync
    assign sync_sym = pulse_sync[1] & (&rd_s2) & check_s2;
    assign frame_ok = frame_valid & (check_s2 == ^rd_s2);
    assign word_nxt = {asm_word[WORD_W-LANES-1:0], rd_s2};

    // Receiver state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state; sync has priority over any strobe in the same cycle
    always_comb begin
        state_nxt = state;
        shift     = 1'b0;
        done      = 1'b0;
        if (sync_sym) begin
            state_nxt = RECV;
        end else if (state == RECV && strobe) begin
            shift = 1'b1;
            if (beat_cnt == CNT_W'(BEATS - 1)) begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
        end
    end

    // Assembly register, beat counter and running frame check
    always_ff @(posedge clk) begin
        if (rst) begin
            asm_word    <= '0;
            rd_echo     <= '0;
            beat_cnt    <= '0;
            frame_valid <= 1'b1;
        end else if (sync_sym) begin
            beat_cnt    <= '0;
            frame_valid <= 1'b1;
        end else if (shift) begin
            asm_word    <= word_nxt;
            rd_echo     <= asm_word[WORD_W-1 -: LANES];
            frame_valid <= frame_ok;
            beat_cnt    <= done ? '0 : beat_cnt + CNT_W'(1);
        end
    end

    assign do_pop  = pop & ~fifo_empty;
    assign push_ok = done & frame_ok;
    assign do_push = push_ok & (~fifo_full | do_pop);
    assign drop    = push_ok & fifo_full & ~do_pop;
    assign bad     = done & ~frame_ok;

    // Next head value: the incoming word when it lands where the read pointer will be
    always_comb begin
        rd_ptr_nxt = rd_ptr + PTR_W'(do_pop);
        count_nxt  = fifo_count + FCNT_W'(do_push) - FCNT_W'(do_pop);
        head_nxt   = mem[rd_ptr_nxt];
        if (count_nxt == '0)
            head_nxt = '0;
        else if (do_push && wr_ptr == rd_ptr_nxt)
            head_nxt = word_nxt;
    end

    // FIFO storage carries no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= word_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            fifo_empty <= 1'b1;
            fifo_full  <= 1'b0;
            rd_data    <= '0;
        end else begin
            rd_ptr     <= rd_ptr_nxt;
            wr_ptr     <= wr_ptr + PTR_W'(do_push);
            fifo_count <= count_nxt;
            fifo_empty <= (count_nxt == '0);
            fifo_full  <= (count_nxt == FCNT_W'(FIFO_DEPTH));
            rd_data    <= head_nxt;
        end
    end

    // A new error in the same cycle as clr_err survives the clear
    always_comb begin
        err_base = clr_err ? '0 : err_count;
        err_nxt  = err_base;
        if (bad && err_base != '1) err_nxt = err_base + ERR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow   <= 1'b0;
            parity_err <= 1'b0;
            err_count  <= '0;
        end else begin
            if (drop)         overflow <= 1'b1;
            else if (clr_err) overflow <= 1'b0;
            if (bad)          parity_err <= 1'b1;
            else if (clr_err) parity_err <= 1'b0;
            err_count <= err_nxt;
        end
    end

    assign frame_busy = (state == RECV);
    assign irq        = irq_en & (~fifo_empty | overflow | parity_err);

endmodule
